// File: rtl/one_hot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encodings and counter sizing.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  // Dwell counter width covers the full DWELL range of 1..255.
  localparam int unsigned DWELL_CNT_W = 8;

endpackage

// File: rtl/one_hot_scan_decoder_if.sv
// Control/status bundle between a controller and the one-hot scan decoder.
interface one_hot_scan_decoder_if
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 4
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             en;
  mode_e            mode;
  logic [SEL_W-1:0] a;
  logic             load;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, a, load,
    input  out, idx, wrap
  );

  modport slave (
    input  en, mode, a, load,
    output out, idx, wrap
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// Counts enabled scan cycles 0..DWELL-1; tick marks the cycle on which the index should step.
module scan_dwell_counter
  import decoder_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic tick
);

  localparam logic [DWELL_CNT_W-1:0] LAST = DWELL_CNT_W'(DWELL - 1);

  logic [DWELL_CNT_W-1:0] cnt_q, cnt_d;

  // Step request: an advancing cycle that lands on the last dwell count.
  always_comb begin
    tick = advance && (cnt_q == LAST);
  end

  // Clear wins over advance; the count rolls back to zero on each step.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DWELL_CNT_W'(1);
    end
  end

  // Dwell count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/one_hot_scan_decoder.sv
// One-hot decoder with direct select, up/down scanning with per-step dwell, and hold.
module one_hot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  one_hot_scan_decoder_if.slave   bus
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  logic direct_c, up_c, down_c, load_c, clear_c, advance_c, tick_c;

  // Qualify the mode with the global enable; load only counts in scan modes.
  always_comb begin
    direct_c  = bus.en && (bus.mode == MODE_DIRECT);
    up_c      = bus.en && (bus.mode == MODE_SCAN_UP);
    down_c    = bus.en && (bus.mode == MODE_SCAN_DOWN);
    load_c    = (up_c || down_c) && bus.load;
    clear_c   = direct_c || load_c;
    advance_c = (up_c || down_c) && !bus.load;
  end

  scan_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_c),
    .advance (advance_c),
    .tick    (tick_c)
  );

  // Next index, wrap pulse and one-hot decode of the next index.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    out_d  = '0;
    if (direct_c || load_c) begin
      idx_d = bus.a;
    end else if (tick_c && up_c) begin
      idx_d  = idx_q + SEL_W'(1);
      wrap_d = (idx_q == {SEL_W{1'b1}});
    end else if (tick_c && down_c) begin
      idx_d  = idx_q - SEL_W'(1);
      wrap_d = (idx_q == '0);
    end
    if (bus.en) begin
      out_d[idx_d] = 1'b1;
    end
  end

  // Output and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_one_hot_scan_decoder.sv
// Bench for one_hot_scan_decoder: three builds share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_one_hot_scan_decoder;
  import decoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  mode_e      md;
  logic [3:0] a;
  logic       load;

  int checks   = 0;
  int failures = 0;

  // Instance 0: SEL_W=4 DWELL=1, instance 1: SEL_W=4 DWELL=3, instance 2: SEL_W=2 DWELL=1.
  int sw[3] = '{4, 4, 2};
  int dw[3] = '{1, 3, 1};

  int   m_idx[3];
  int   m_cnt[3];
  logic m_wrap[3];
  logic m_on[3];

  logic [31:0] g_out[3];
  logic [31:0] g_idx[3];
  logic [31:0] g_wrap[3];

  one_hot_scan_decoder_if #(.SEL_W(4)) bi0 ();
  one_hot_scan_decoder_if #(.SEL_W(4)) bi1 ();
  one_hot_scan_decoder_if #(.SEL_W(2)) bi2 ();

  assign bi0.en = en;  assign bi0.mode = md;  assign bi0.a = a;       assign bi0.load = load;
  assign bi1.en = en;  assign bi1.mode = md;  assign bi1.a = a;       assign bi1.load = load;
  assign bi2.en = en;  assign bi2.mode = md;  assign bi2.a = a[1:0];  assign bi2.load = load;

  one_hot_scan_decoder #(.SEL_W(4), .DWELL(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(bi0));
  one_hot_scan_decoder #(.SEL_W(4), .DWELL(3)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bi1));
  one_hot_scan_decoder #(.SEL_W(2), .DWELL(1)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(bi2));

  assign g_out[0]  = 32'(bi0.out);  assign g_idx[0] = 32'(bi0.idx);  assign g_wrap[0] = 32'(bi0.wrap);
  assign g_out[1]  = 32'(bi1.out);  assign g_idx[1] = 32'(bi1.idx);  assign g_wrap[1] = 32'(bi1.wrap);
  assign g_out[2]  = 32'(bi2.out);  assign g_idx[2] = 32'(bi2.idx);  assign g_wrap[2] = 32'(bi2.wrap);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k]  = 0;
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
      m_on[k]   = 1'b0;
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs present at that edge.
  task automatic model_clk();
    for (int k = 0; k < 3; k++) begin
      int n;
      int av;
      n  = 1 << sw[k];
      av = int'(a) % n;
      m_wrap[k] = 1'b0;
      if (!en) begin
        m_on[k] = 1'b0;
      end else begin
        m_on[k] = 1'b1;
        case (md)
          MODE_DIRECT: begin
            m_idx[k] = av;
            m_cnt[k] = 0;
          end
          MODE_HOLD: ;
          default: begin
            if (load) begin
              m_idx[k] = av;
              m_cnt[k] = 0;
            end else if (m_cnt[k] + 1 < dw[k]) begin
              m_cnt[k] = m_cnt[k] + 1;
            end else begin
              m_cnt[k] = 0;
              if (md == MODE_SCAN_UP) begin
                m_idx[k]  = (m_idx[k] + 1) % n;
                m_wrap[k] = (m_idx[k] == 0);
              end else begin
                m_idx[k]  = (m_idx[k] + n - 1) % n;
                m_wrap[k] = (m_idx[k] == n - 1);
              end
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_out;
      exp_out = m_on[k] ? (32'd1 << m_idx[k]) : 32'd0;
      check_val($sformatf("out%0d", k),  g_out[k],  exp_out);
      check_val($sformatf("idx%0d", k),  g_idx[k],  32'(m_idx[k]));
      check_val($sformatf("wrap%0d", k), g_wrap[k], 32'(m_wrap[k]));
      check_val($sformatf("onehot%0d", k), 32'($countones(g_out[k]) <= 1), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clk();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    md    = MODE_DIRECT;
    a     = 4'd0;
    load  = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    rst_n = 1'b1;

    // First enabled scan cycle after reset shows index 0 (DWELL=3 build).
    en = 1'b1; md = MODE_SCAN_UP;
    step();
    check_val("first_scan_out", g_out[1], 32'h0001);

    // Direct decode of 9.
    md = MODE_DIRECT; a = 4'd9;
    step();
    check_val("direct_out",  g_out[0],  32'h0200);
    check_val("direct_idx",  g_idx[0],  32'd9);
    check_val("direct_wrap", g_wrap[0], 32'd0);

    // DWELL=3 up-scan from 14 through the wrap.
    md = MODE_SCAN_UP; load = 1'b1; a = 4'd14;
    step();
    load = 1'b0;
    check_val("up_load_idx", g_idx[1], 32'd14);
    step(); step();
    check_val("up_dwell_idx", g_idx[1], 32'd14);
    step();
    check_val("up_step_idx", g_idx[1], 32'd15);
    step(); step();
    check_val("up_dwell15_idx", g_idx[1], 32'd15);
    step();
    check_val("up_wrap_idx",  g_idx[1],  32'd0);
    check_val("up_wrap",      g_wrap[1], 32'd1);
    check_val("up_wrap_out",  g_out[1],  32'h0001);
    step();
    check_val("up_wrap_clr",  g_wrap[1], 32'd0);

    // DWELL=1 down-scan across zero.
    md = MODE_SCAN_DOWN; load = 1'b1; a = 4'd1;
    step();
    load = 1'b0;
    check_val("dn_load_idx", g_idx[0], 32'd1);
    step();
    check_val("dn_idx0",  g_idx[0],  32'd0);
    check_val("dn_wrap0", g_wrap[0], 32'd0);
    step();
    check_val("dn_wrap_idx", g_idx[0],  32'd15);
    check_val("dn_wrap_out", g_out[0],  32'h8000);
    check_val("dn_wrap",     g_wrap[0], 32'd1);
    step();
    check_val("dn_wrap_clr", g_wrap[0], 32'd0);

    // Disable for four cycles mid-scan, then resume from the held dwell count.
    md = MODE_SCAN_UP; load = 1'b1; a = 4'd5;
    step();
    load = 1'b0; en = 1'b0;
    repeat (4) step();
    check_val("dis_out", g_out[1], 32'd0);
    check_val("dis_idx", g_idx[1], 32'd5);
    en = 1'b1;
    step();
    check_val("resume_out", g_out[1], 32'h0020);
    step(); step();
    check_val("resume_step_idx", g_idx[1], 32'd6);

    // Hold ignores load.
    md = MODE_HOLD; load = 1'b1; a = 4'd3;
    step();
    load = 1'b0;
    check_val("hold_idx",  g_idx[1],  32'd6);
    check_val("hold_wrap", g_wrap[1], 32'd0);
    step();

    // Direct ignores load too.
    md = MODE_DIRECT; load = 1'b1; a = 4'd7;
    step();
    load = 1'b0;

    // Asynchronous reset between clock edges.
    md = MODE_SCAN_UP;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("async_rst_out", g_out[0], 32'd0);
    #2 rst_n = 1'b1;
    step();
    check_val("post_rst_idx", g_idx[1], 32'd0);
    check_val("post_rst_out", g_out[1], 32'h0001);

    // SEL_W=2 build cycling through all outputs twice.
    load = 1'b1; a = 4'd0;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("sel2_out",  g_out[2],  32'd1 << ((i + 1) % 4));
      check_val("sel2_wrap", g_wrap[2], 32'(((i + 1) % 4) == 0));
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 99) < 85);
      md   = mode_e'($urandom_range(0, 3));
      load = ($urandom_range(0, 99) < 20);
      a    = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_hot_scan_decoder.md
ONE_HOT_SCAN_DECODER -- requirements
Module: one_hot_scan_decoder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter SEL_W, default 4, which sets the select width.
REQ-003 The block SHALL have derived parameter OUT_W = 2**SEL_W, which sets the one-hot output width (16 at default).
REQ-004 The block SHALL have parameter DWELL, default 1, range 1..255, giving the number of cycles each output stays active in scan modes.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  global enable; 0 forces out to zero and freezes all state.
REQ-008 mode  input  2  operating mode: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-009 a  input  SEL_W  select value: the decode source in DIRECT mode, the load value in scan modes.
REQ-010 load  input  1  one-cycle pulse that sets the scan index to a.
REQ-011 out  output  OUT_W  registered one-hot decode of idx; all zero when disabled.
REQ-012 idx  output  SEL_W  current registered index.
REQ-013 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-014 In DIRECT mode with en=1, idx SHALL become a, and out SHALL become one-hot(a), one cycle after a is sampled (latency 1).
REQ-015 In SCAN_UP mode with en=1, a dwell counter SHALL count 0..DWELL-1.
- When it reaches DWELL-1, idx SHALL increment and the counter SHALL clear.
REQ-016 SCAN_DOWN SHALL behave as SCAN_UP, except that idx decrements.
REQ-017 In SCAN_UP, a step from OUT_W-1 to 0 SHALL wrap, and wrap SHALL be 1 for exactly the cycle in which idx becomes 0.
REQ-018 In SCAN_DOWN, a step from 0 to OUT_W-1 SHALL wrap, and wrap SHALL pulse in the same way.
REQ-019 In HOLD mode, idx, out and the dwell counter SHALL keep their values, and wrap SHALL be 0.
REQ-020 With en=1 and load=1 in a scan mode:
- idx SHALL become a;
- the dwell counter SHALL clear;
- wrap SHALL be 0 that cycle;
- load SHALL take priority over the step.
REQ-021 In DIRECT and HOLD modes, load SHALL be ignored.
REQ-022 With en=0:
- out SHALL be all zero on the next cycle;
- idx and the dwell counter SHALL hold;
- wrap SHALL be 0;
- load SHALL be ignored.
REQ-023 When en rises to 1, out SHALL show one-hot(idx) on the next cycle, and scanning SHALL resume from the held dwell count.
REQ-024 A mode change SHALL take effect on the cycle it is sampled.
- A change between scan modes SHALL keep idx and the dwell count.
- A change into DIRECT SHALL clear the dwell counter.
REQ-025 With DWELL=1, idx SHALL step every enabled scan cycle.
REQ-026 out SHALL always be zero or exactly one-hot, and no output glitch SHALL occur, because out is fully registered.
REQ-027 wrap SHALL only assert in SCAN_UP or SCAN_DOWN with en=1 and load=0.

Reset
REQ-028 While rst_n=0, the block SHALL hold:
- out=0, idx=0, wrap=0;
- dwell counter=0.
REQ-029 Assertion of rst_n mid-scan SHALL clear all state immediately, independent of clk.
REQ-030 After rst_n deasserts, the first enabled cycle SHALL drive out=one-hot(idx=0) in scan modes, or one-hot(a) in DIRECT.

Structure
REQ-031 The mode encodings (DIRECT, SCAN_UP, SCAN_DOWN, HOLD) SHALL be constants in the shared package decoder_pkg, used by both the RTL and the bench.
REQ-032 The dwell counter SHALL be one sub-module, scan_dwell_counter (parameter DWELL), with:
- inputs clear and advance;
- output tick.
REQ-033 The one-hot decode SHALL be a combinational function of the next idx, feeding the out register.

Verification
REQ-034 Default params, DIRECT, en=1, a=4'd9 -> one cycle later out=16'h0200, idx=9, wrap=0.
REQ-035 SCAN_UP, DWELL=3, load a=14 -> idx=14 for 3 cycles, then 15 for 3 cycles, then 0 with wrap=1 for one cycle, out=16'h0001.
REQ-036 SCAN_DOWN, DWELL=1, idx=1 -> next cycle idx=0, then idx=15, out=16'h8000, wrap=1 on that cycle only.
REQ-037 SCAN_UP, idx=5, en=0 for 4 cycles -> out=0, idx=5 held; after en=1, out=16'h0020, then stepping resumes.
REQ-038 Mid-scan rst_n pulse between clock edges -> out, idx and wrap go 0 immediately; after release, SCAN_UP starts from idx=0.
REQ-039 SEL_W=2 build, SCAN_UP, DWELL=1 -> out cycles 4'b0001, 0010, 0100, 1000, 0001, with wrap on each return to 0001.
